key_cfg_lookup: RTL
===================

KEY_CFG_LOOKUP -- requirements
Module: key_cfg_lookup

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, control-stream data width; only 256 is supported.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, control-stream tuser width.
REQ-003 SHALL have parameters STAGE_ID (default 0), KEY_EX_ID (default 1) and SUB_UNIT_ID (default 0), the control-packet match identifiers.
REQ-004 SHALL have parameter PHV_LEN, default 2304, PHV width.
REQ-005 SHALL have parameters KEY_OFF (default 68) and KEY_LEN (default 257), the offset-entry and mask-entry widths.
REQ-006 SHALL have parameter TBL_DEPTH, default 32, table depth: power of 2, 2..256; IDX_W = log2(TBL_DEPTH).
REQ-007 SHALL have parameter VLAN_IDX_LSB, default 4; table index = vlan_in[VLAN_IDX_LSB +: IDX_W].
REQ-008 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset): reset rst_n, synchronous, active-low; clock clk.
REQ-009 SHALL have data-side inputs phv_in [PHV_LEN], phv_valid_in, vlan_in [12], vlan_valid_in and out_ready (1 each unless stated); outputs phv_ready_out and vlan_ready_out (1 each).
REQ-010 SHALL have data-side outputs phv_out [PHV_LEN], key_offset_out [KEY_OFF], key_mask_out [KEY_LEN] and out_valid [1].
REQ-011 SHALL have control ports c_s_axis_tdata/tuser/tkeep/tvalid/tlast (in) and c_m_axis_tdata/tuser/tkeep/tvalid/tlast (out), widths per REQ-001/002, tkeep = data width/8.
REQ-012 SHALL have output cfg_wr_cnt [16], a saturating count of committed table writes.

Function
REQ-013 SHALL join PHV and VLAN: a lookup is accepted only in a cycle with phv_valid_in && vlan_valid_in && pipeline not stalled; phv_ready_out = vlan_ready_out = !stall.
REQ-014 SHALL use a 2-stage lookup pipeline: stage 1 registers the index and PHV; stage 2 registers the table data and PHV; out_valid rises 2 cycles after acceptance.
REQ-015 SHALL define stall = out_valid && !out_ready; while stalled, all pipeline registers and outputs hold their values.
REQ-016 SHALL read the tables read-first: a write and a read to the same index in the same cycle return the old entry; the new entry is visible from the next cycle.
REQ-017 SHALL run the control FSM with states IDLE, PARSE, WR_OFF, WR_MASK and FLUSH.
REQ-018 IDLE SHALL, on tvalid, capture beat 0 into a hold register and go to PARSE.
REQ-019 PARSE SHALL, on tvalid, decode beat 1: mod_id = tdata[112+:8], resv = tdata[120+:4], sub = tdata[124+:4], flag = tdata[64+:16], idx = tdata[128+:8].
REQ-020 A match SHALL require mod_id[7:3] == STAGE_ID, mod_id[2:0] == KEY_EX_ID, sub == SUB_UNIT_ID and flag == 16'hf2f1; on a match, go to WR_OFF if resv == 0, otherwise to WR_MASK with beat count 0.
REQ-021 A non-matching packet SHALL be forwarded whole (beat 0 from the hold register, then the remaining beats) and the FSM SHALL go to FLUSH.
REQ-022 Payload beats SHALL be byte-swapped: byte i of the swapped word = tdata byte 31-i.
REQ-023 WR_OFF SHALL, on tvalid, write offset[idx] = swapped[255 -: KEY_OFF] and go to FLUSH.
REQ-024 WR_MASK SHALL, over MASK_BEATS = ceil(KEY_LEN/256) valid beats, fill mask bits MSB-first from the top of each swapped beat.
REQ-025 The last WR_MASK beat SHALL contribute only the remaining KEY_LEN-256*(MASK_BEATS-1) bits; the entry is committed on that beat, then the FSM goes to FLUSH.
REQ-026 A write with idx >= TBL_DEPTH SHALL be discarded, cfg_wr_cnt SHALL not increment, and the packet SHALL still be consumed.
REQ-027 On tlast before the final WR_MASK beat, the write SHALL be aborted (no commit) and the FSM SHALL return to IDLE.
REQ-028 FLUSH SHALL consume (matched packet) or forward (unmatched packet) beats until tvalid && tlast, then return to IDLE.
REQ-029 Matched packets SHALL never appear on c_m_axis; forwarded beats SHALL appear unchanged, exactly 2 cycles after input, with no inserted gaps.
REQ-030 A single-beat packet (tlast on beat 0) SHALL be forwarded and the FSM SHALL return to IDLE.
REQ-031 cfg_wr_cnt SHALL increment by 1 per committed write and saturate at 16'hFFFF.

Reset
REQ-032 While rst_n = 0 at a clk edge: FSM -> IDLE; out_valid, c_m_axis_* and cfg_wr_cnt -> 0; pipeline valids cleared; phv_out, key_offset_out and key_mask_out -> 0.
REQ-033 Reset SHALL not clear table contents; reset mid-packet SHALL discard the partial write, and post-reset beats up to the next tlast SHALL be treated as a new packet.

Verification
REQ-034 Test: offset write, idx 5, payload swapped[255-:68] = 68'h123456789ABCDEF01; then lookup vlan_in = 12'h050 -> 2 cycles later key_offset_out = that value, cfg_wr_cnt = 1.
REQ-035 Test: 2-beat mask write, idx 3, beat 0 all-ones, beat 1 swapped bit 255 = 0 -> key_mask_out = {256'hFF..F, 1'b0} for vlan_in = 12'h030.
REQ-036 Test: 3-beat packet with flag = 16'hf2f0 -> all 3 beats emerge unchanged on c_m_axis, 2-cycle latency, back-to-back; no table change.
REQ-037 Test: out_ready low for 4 cycles while 3 lookups stream -> outputs hold, no loss or duplication, original order preserved.
REQ-038 Test: write idx 40 with TBL_DEPTH = 32 -> no table change, cfg_wr_cnt unchanged; same-cycle write/read at idx 7 -> old value returned, then new value.
REQ-039 Test: rst_n asserted during WR_MASK beat 0 -> outputs 0, table entry unchanged, next valid packet is processed normally.

Source files
------------

// File: rtl/key_cfg_lookup_if.sv
// Control-stream bundle (tdata/tuser/tkeep/tvalid/tlast) shared by the
// configuration input and the pass-through output of key_cfg_lookup.
interface key_cfg_lookup_if #(
  parameter int DW = 256,
  parameter int UW = 128
) ();
  logic [DW-1:0]   tdata;
  logic [UW-1:0]   tuser;
  logic [DW/8-1:0] tkeep;
  logic            tvalid;
  logic            tlast;

  modport master (output tdata, tuser, tkeep, tvalid, tlast);
  modport slave  (input  tdata, tuser, tkeep, tvalid, tlast);
endinterface

// File: rtl/key_cfg_lookup.sv
// VLAN-indexed key offset/mask lookup. Tables are programmed in-band from the
// control stream; control packets not addressed to this block are forwarded.
module key_cfg_lookup #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int KEY_EX_ID            = 1,
  parameter int SUB_UNIT_ID          = 0,
  parameter int PHV_LEN              = 2304,
  parameter int KEY_OFF              = 68,
  parameter int KEY_LEN              = 257,
  parameter int TBL_DEPTH            = 32,
  parameter int VLAN_IDX_LSB         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PHV_LEN-1:0]  phv_in,
  input  logic                phv_valid_in,
  input  logic [11:0]         vlan_in,
  input  logic                vlan_valid_in,
  input  logic                out_ready,
  output logic                phv_ready_out,
  output logic                vlan_ready_out,
  output logic [PHV_LEN-1:0]  phv_out,
  output logic [KEY_OFF-1:0]  key_offset_out,
  output logic [KEY_LEN-1:0]  key_mask_out,
  output logic                out_valid,
  key_cfg_lookup_if.slave     c_s_axis,
  key_cfg_lookup_if.master    c_m_axis,
  output logic [15:0]         cfg_wr_cnt
);
  localparam int DW         = C_S_AXIS_DATA_WIDTH;
  localparam int UW         = C_S_AXIS_TUSER_WIDTH;
  localparam int KW         = DW / 8;
  localparam int IDX_W      = $clog2(TBL_DEPTH);
  localparam int MASK_BEATS = (KEY_LEN + DW - 1) / DW;
  localparam int MB_W       = MASK_BEATS * DW;

  typedef enum logic [2:0] {IDLE, PARSE, WR_OFF, WR_MASK, FLUSH} state_t;

  state_t state_q, state_d;
  logic   fwd_q, fwd_d;
  logic [7:0] idx_q, idx_d, beat_q, beat_d;
  logic [MB_W-1:0] mask_buf_q, mask_buf_d;
  logic [DW-1:0] hold_data_q, hold_data_d, a_data_q, a_data_d, cm_data_q, cm_data_d;
  logic [UW-1:0] hold_user_q, hold_user_d, a_user_q, a_user_d, cm_user_q, cm_user_d;
  logic [KW-1:0] hold_keep_q, hold_keep_d, a_keep_q, a_keep_d, cm_keep_q, cm_keep_d;
  logic a_valid_q, a_valid_d, a_last_q, a_last_d, cm_valid_q, cm_valid_d, cm_last_q, cm_last_d;
  logic [15:0] cnt_q, cnt_d;

  logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic [PHV_LEN-1:0] s1_phv_q, s1_phv_d, phv_out_q, phv_out_d;
  logic [KEY_OFF-1:0] key_off_q, key_off_d;
  logic [KEY_LEN-1:0] key_mask_q, key_mask_d;

  logic [KEY_OFF-1:0] off_tbl_q  [TBL_DEPTH];
  logic [KEY_LEN-1:0] mask_tbl_q [TBL_DEPTH];

  logic [DW-1:0]      swapped;
  logic [MB_W+DW-1:0] mask_cat;
  logic [MB_W-1:0]    mask_shift;
  logic [7:0]  mod_id, hdr_idx;
  logic [3:0]  resv, sub;
  logic [15:0] flag;
  logic hdr_match, idx_ok, ld_hold, off_we, mask_we, stall, accept, unused_ok;

  always_comb begin
    swapped = '0;
    for (int i = 0; i < KW; i++) swapped[8*i +: 8] = c_s_axis.tdata[8*(KW-1-i) +: 8];
  end

  assign mod_id    = c_s_axis.tdata[112 +: 8];
  assign resv      = c_s_axis.tdata[120 +: 4];
  assign sub       = c_s_axis.tdata[124 +: 4];
  assign flag      = c_s_axis.tdata[64 +: 16];
  assign hdr_idx   = c_s_axis.tdata[128 +: 8];
  assign hdr_match = (mod_id[7:3] == 5'(STAGE_ID)) && (mod_id[2:0] == 3'(KEY_EX_ID)) &&
                     (sub == 4'(SUB_UNIT_ID)) && (flag == 16'hf2f1);
  assign idx_ok    = {1'b0, idx_q} < 9'(TBL_DEPTH);
  // Mask beats shift in at the bottom, so the first beat ends up at the top.
  assign mask_cat   = {mask_buf_q, swapped};
  assign mask_shift = mask_cat[MB_W-1:0];
  assign unused_ok  = ^{vlan_in, mask_cat[MB_W +: DW]};

  always_comb begin
    state_d     = state_q;
    fwd_d       = fwd_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    mask_buf_d  = mask_buf_q;
    hold_data_d = hold_data_q;
    hold_user_d = hold_user_q;
    hold_keep_d = hold_keep_q;
    a_valid_d   = 1'b0;
    a_data_d    = c_s_axis.tdata;
    a_user_d    = c_s_axis.tuser;
    a_keep_d    = c_s_axis.tkeep;
    a_last_d    = c_s_axis.tlast;
    ld_hold     = 1'b0;
    off_we      = 1'b0;
    mask_we     = 1'b0;
    case (state_q)
      IDLE: if (c_s_axis.tvalid) begin
        if (c_s_axis.tlast) begin
          a_valid_d = 1'b1;
        end else begin
          hold_data_d = c_s_axis.tdata;
          hold_user_d = c_s_axis.tuser;
          hold_keep_d = c_s_axis.tkeep;
          state_d     = PARSE;
        end
      end
      PARSE: if (c_s_axis.tvalid) begin
        idx_d  = hdr_idx;
        beat_d = '0;
        if (hdr_match) begin
          fwd_d = 1'b0;
          if (c_s_axis.tlast)   state_d = IDLE;
          else if (resv == '0) state_d = WR_OFF;
          else                  state_d = WR_MASK;
        end else begin
          fwd_d     = 1'b1;
          ld_hold   = 1'b1;
          a_valid_d = 1'b1;
          state_d   = c_s_axis.tlast ? IDLE : FLUSH;
        end
      end
      WR_OFF: if (c_s_axis.tvalid) begin
        off_we  = idx_ok && rst_n;
        state_d = c_s_axis.tlast ? IDLE : FLUSH;
      end
      WR_MASK: if (c_s_axis.tvalid) begin
        mask_buf_d = mask_shift;
        if (beat_q == 8'(MASK_BEATS - 1)) begin
          mask_we = idx_ok && rst_n;
          state_d = c_s_axis.tlast ? IDLE : FLUSH;
        end else if (c_s_axis.tlast) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      FLUSH: if (c_s_axis.tvalid) begin
        a_valid_d = fwd_q;
        if (c_s_axis.tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Beat 0 of an unmatched packet jumps straight from the hold register to
    // the output so the forwarded stream keeps a uniform two-cycle latency.
    cm_valid_d = ld_hold | a_valid_q;
    cm_data_d  = ld_hold ? hold_data_q : a_data_q;
    cm_user_d  = ld_hold ? hold_user_q : a_user_q;
    cm_keep_d  = ld_hold ? hold_keep_q : a_keep_q;
    cm_last_d  = ld_hold ? 1'b0 : a_last_q;

    cnt_d = cnt_q;
    if ((off_we || mask_we) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    stall       = out_valid_q && !out_ready;
    accept      = phv_valid_in && vlan_valid_in && !stall;
    s1_valid_d  = s1_valid_q;
    s1_idx_d    = s1_idx_q;
    s1_phv_d    = s1_phv_q;
    out_valid_d = out_valid_q;
    phv_out_d   = phv_out_q;
    key_off_d   = key_off_q;
    key_mask_d  = key_mask_q;
    if (!stall) begin
      s1_valid_d  = accept;
      out_valid_d = s1_valid_q;
      if (accept) begin
        s1_idx_d = vlan_in[VLAN_IDX_LSB +: IDX_W];
        s1_phv_d = phv_in;
      end
      if (s1_valid_q) begin
        phv_out_d  = s1_phv_q;
        key_off_d  = off_tbl_q[s1_idx_q];
        key_mask_d = mask_tbl_q[s1_idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;       fwd_q <= 1'b0;        idx_q <= '0;        beat_q <= '0;
      mask_buf_q <= '0;      hold_data_q <= '0;    hold_user_q <= '0;  hold_keep_q <= '0;
      a_valid_q <= 1'b0;     a_data_q <= '0;       a_user_q <= '0;     a_keep_q <= '0;
      a_last_q <= 1'b0;      cm_valid_q <= 1'b0;   cm_data_q <= '0;    cm_user_q <= '0;
      cm_keep_q <= '0;       cm_last_q <= 1'b0;    cnt_q <= '0;
      s1_valid_q <= 1'b0;    s1_idx_q <= '0;       s1_phv_q <= '0;     out_valid_q <= 1'b0;
      phv_out_q <= '0;       key_off_q <= '0;      key_mask_q <= '0;
    end else begin
      state_q <= state_d;    fwd_q <= fwd_d;       idx_q <= idx_d;     beat_q <= beat_d;
      mask_buf_q <= mask_buf_d;   hold_data_q <= hold_data_d;
      hold_user_q <= hold_user_d; hold_keep_q <= hold_keep_d;
      a_valid_q <= a_valid_d; a_data_q <= a_data_d; a_user_q <= a_user_d; a_keep_q <= a_keep_d;
      a_last_q <= a_last_d;  cm_valid_q <= cm_valid_d; cm_data_q <= cm_data_d;
      cm_user_q <= cm_user_d; cm_keep_q <= cm_keep_d; cm_last_q <= cm_last_d; cnt_q <= cnt_d;
      s1_valid_q <= s1_valid_d; s1_idx_q <= s1_idx_d; s1_phv_q <= s1_phv_d;
      out_valid_q <= out_valid_d; phv_out_q <= phv_out_d;
      key_off_q <= key_off_d; key_mask_q <= key_mask_d;
    end
  end

  // Tables survive reset; the write strobes are already gated by rst_n.
  always_ff @(posedge clk) begin
    if (off_we)  off_tbl_q[idx_q[IDX_W-1:0]]  <= swapped[DW-1 -: KEY_OFF];
    if (mask_we) mask_tbl_q[idx_q[IDX_W-1:0]] <= mask_shift[MB_W-1 -: KEY_LEN];
  end

  assign phv_ready_out   = !stall;
  assign vlan_ready_out  = !stall;
  assign out_valid       = out_valid_q;
  assign phv_out         = phv_out_q;
  assign key_offset_out  = key_off_q;
  assign key_mask_out    = key_mask_q;
  assign cfg_wr_cnt      = cnt_q;
  assign c_m_axis.tvalid = cm_valid_q;
  assign c_m_axis.tdata  = cm_data_q;
  assign c_m_axis.tuser  = cm_user_q;
  assign c_m_axis.tkeep  = cm_keep_q;
  assign c_m_axis.tlast  = cm_last_q;
endmodule
